// File: rtl/wlo_ctrl_unit.sv
// Host command controller for the word-length-optimisation emulator: decodes RX byte
// commands, commits switch banks atomically through a shadow bank, and streams
// ACK/NAK, MSE results and switch readback over a ready/valid TX port.
module wlo_ctrl_unit #(
  parameter int         NUM_CHAN   = 15,
  parameter int         SW_W       = 8,
  parameter int         MSE_BYTES  = 8,
  parameter logic [7:0] SW_RST     = 8'h1E,
  parameter int         RX_TIMEOUT = 65535,
  parameter int         RST_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           com_rxvalid,
  input  logic [7:0]                     com_rxdata,
  output logic                           com_txvalid,
  input  logic                           com_txready,
  output logic [7:0]                     com_txdata,
  input  logic [8*MSE_BYTES-1:0]         mse_data,
  input  logic                           mse_valid,
  output logic [NUM_CHAN-1:0][SW_W-1:0]  sw_int,
  output logic [NUM_CHAN-1:0][SW_W-1:0]  sw_frac,
  output logic                           start,
  output logic                           soft_rstn,
  output logic                           busy
);

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_FRAC  = 8'h02;
  localparam logic [7:0] CMD_INT   = 8'h03;
  localparam logic [7:0] CMD_RST   = 8'h04;
  localparam logic [7:0] CMD_RB    = 8'h05;
  localparam logic [7:0] CMD_MSE   = 8'h06;
  localparam logic [7:0] ACK_BYTE  = 8'hA5;
  localparam logic [7:0] NAK_BYTE  = 8'hEE;

  localparam int RB_BYTES = 2 * NUM_CHAN;
  localparam int CNT_A    = (RB_BYTES > MSE_BYTES) ? RB_BYTES : MSE_BYTES;
  localparam int CNT_MAX  = (CNT_A > RST_CYCLES) ? CNT_A : RST_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int TMO_W    = $clog2(RX_TIMEOUT + 1);

  localparam logic [SW_W-1:0] SW_RST_VAL = SW_RST[SW_W-1:0];

  typedef enum logic [3:0] {
    IDLE,
    RX_PAY,
    COMMIT,
    TX_ACK,
    TX_NAK,
    TX_MSE,
    TX_RB,
    PULSE_START,
    PULSE_RST
  } state_t;

  state_t                         state;
  state_t                         state_n;
  logic [CNT_W-1:0]               cnt;
  logic [CNT_W-1:0]               cnt_n;
  logic [TMO_W-1:0]               tmo_cnt;
  logic                           tmo_hit;
  logic                           sel_int;
  logic [NUM_CHAN-1:0][SW_W-1:0]  shadow;
  logic [8*MSE_BYTES-1:0]         mse_buf;
  logic [8*MSE_BYTES-1:0]         mse_tx;
  logic [8*MSE_BYTES-1:0]         mse_src;
  logic                           pending;
  logic                           rst_cmd;
  logic                           tx_done;
  logic                           tx_load;
  logic                           tx_next;
  logic [7:0]                     tx_byte;

  assign tx_done = com_txvalid && com_txready;
  assign tmo_hit = (state == RX_PAY) && !com_rxvalid &&
                   (tmo_cnt == TMO_W'(RX_TIMEOUT - 1));
  assign rst_cmd = (state == IDLE) && com_rxvalid && (com_rxdata == CMD_RST);

  always_comb begin
    // NOTE: defaults first on every combinational output so no path leaves one unassigned (no latch).
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (com_rxvalid) begin
          case (com_rxdata)
            CMD_START:         state_n = PULSE_START;
            CMD_FRAC, CMD_INT: state_n = RX_PAY;
            CMD_RST:           state_n = PULSE_RST;
            CMD_RB:            state_n = TX_RB;
            CMD_MSE:           state_n = TX_MSE;
            default:           state_n = TX_NAK;
          endcase
        end else if (pending) begin
          state_n = TX_MSE;
        end
      end
      RX_PAY: begin
        if (com_rxvalid) begin
          if (cnt == CNT_W'(NUM_CHAN - 1)) begin
            state_n = COMMIT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else if (tmo_hit) begin
          state_n = TX_NAK;
          cnt_n   = '0;
        end
      end
      COMMIT: state_n = TX_ACK;
      TX_ACK, TX_NAK: begin
        if (tx_done) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      TX_MSE: begin
        if (tx_done) begin
          if (cnt == CNT_W'(MSE_BYTES - 1)) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      TX_RB: begin
        if (tx_done) begin
          if (cnt == CNT_W'(RB_BYTES - 1)) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      PULSE_START: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      PULSE_RST: begin
        if (cnt == CNT_W'(RST_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Byte to present next: chosen from the state/counter we are about to enter.
  // An MSE send reads its snapshot so a newer strobe cannot tear a frame in flight.
  always_comb begin
    tx_byte = '0;
    mse_src = (state == TX_MSE) ? mse_tx : mse_buf;
    tx_next = (state_n == TX_ACK) || (state_n == TX_NAK) ||
              (state_n == TX_MSE) || (state_n == TX_RB);
    tx_load = (state_n != state) || tx_done;
    case (state_n)
      TX_ACK: tx_byte = ACK_BYTE;
      TX_NAK: tx_byte = NAK_BYTE;
      TX_MSE: begin
        for (int b = 0; b < MSE_BYTES; b++) begin
          if (cnt_n == CNT_W'(b)) tx_byte = mse_src[8*b +: 8];
        end
      end
      TX_RB: begin
        for (int c = 0; c < NUM_CHAN; c++) begin
          if (cnt_n == CNT_W'(c))            tx_byte = 8'(sw_frac[c]);
          if (cnt_n == CNT_W'(NUM_CHAN + c)) tx_byte = 8'(sw_int[c]);
        end
      end
      default: tx_byte = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      tmo_cnt     <= '0;
      sel_int     <= 1'b0;
      com_txvalid <= 1'b0;
      com_txdata  <= '0;
      start       <= 1'b0;
      soft_rstn   <= 1'b1;
      busy        <= 1'b0;
      // NOTE: the shadow and switch banks are plain registers with a defined reset value, so they are reset here like any other state.
      shadow      <= {NUM_CHAN{SW_RST_VAL}};
      sw_int      <= {NUM_CHAN{SW_RST_VAL}};
      sw_frac     <= {NUM_CHAN{SW_RST_VAL}};
      mse_buf     <= '0;
      mse_tx      <= '0;
      pending     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      com_txvalid <= tx_next;
      if (tx_load) com_txdata <= tx_byte;
      start       <= (state_n == PULSE_START);
      soft_rstn   <= (state_n != PULSE_RST);
      busy        <= (state_n != IDLE);

      tmo_cnt <= (state == RX_PAY && !com_rxvalid) ? tmo_cnt + 1'b1 : '0;

      if (state == IDLE && com_rxvalid) sel_int <= (com_rxdata == CMD_INT);

      if (state == RX_PAY && com_rxvalid) begin
        for (int c = 0; c < NUM_CHAN; c++) begin
          if (cnt == CNT_W'(c)) shadow[c] <= com_rxdata[SW_W-1:0];
        end
      end else if (tmo_hit) begin
        shadow <= sel_int ? sw_int : sw_frac;
      end

      if (state == COMMIT) begin
        if (sel_int) sw_int  <= shadow;
        else         sw_frac <= shadow;
      end

      if (mse_valid) mse_buf <= mse_data;
      if (state != TX_MSE && state_n == TX_MSE) mse_tx <= mse_buf;

      // A RESET command discards the result even if it was strobed in that same cycle.
      // Otherwise pending drops once the send starts; a strobe during the send re-arms it.
      if (rst_cmd)                                   pending <= 1'b0;
      else if (mse_valid)                            pending <= 1'b1;
      else if (state != TX_MSE && state_n == TX_MSE) pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wlo_ctrl_unit.sv
// Directed self-checking bench for wlo_ctrl_unit: commands, commits, timeout,
// MSE streaming with backpressure, pulses and reset during readback.
module tb_wlo_ctrl_unit;

  localparam int NUM_CHAN   = 15;
  localparam int SW_W       = 8;
  localparam int MSE_BYTES  = 8;
  localparam int RX_TIMEOUT = 40;
  localparam int RST_CYCLES = 4;

  logic                          clk = 1'b0;
  logic                          rstn = 1'b0;
  logic                          com_rxvalid = 1'b0;
  logic [7:0]                    com_rxdata = 8'h00;
  logic                          com_txvalid;
  logic                          com_txready = 1'b0;
  logic [7:0]                    com_txdata;
  logic [8*MSE_BYTES-1:0]        mse_data = '0;
  logic                          mse_valid = 1'b0;
  logic [NUM_CHAN-1:0][SW_W-1:0] sw_int;
  logic [NUM_CHAN-1:0][SW_W-1:0] sw_frac;
  logic                          start;
  logic                          soft_rstn;
  logic                          busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [NUM_CHAN-1:0][SW_W-1:0] exp_int;
  logic [NUM_CHAN-1:0][SW_W-1:0] exp_frac;
  logic [NUM_CHAN-1:0][SW_W-1:0] rst_bank;
  logic [7:0] rx_q[$];
  bit         stable_ok;

  always #5 clk = ~clk;

  wlo_ctrl_unit #(
    .NUM_CHAN   (NUM_CHAN),
    .SW_W       (SW_W),
    .MSE_BYTES  (MSE_BYTES),
    .SW_RST     (8'h1E),
    .RX_TIMEOUT (RX_TIMEOUT),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .com_rxvalid (com_rxvalid),
    .com_rxdata  (com_rxdata),
    .com_txvalid (com_txvalid),
    .com_txready (com_txready),
    .com_txdata  (com_txdata),
    .mse_data    (mse_data),
    .mse_valid   (mse_valid),
    .sw_int      (sw_int),
    .sw_frac     (sw_frac),
    .start       (start),
    .soft_rstn   (soft_rstn),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    com_rxvalid = 1'b1;
    com_rxdata  = b;
    tick();
    com_rxvalid = 1'b0;
    com_rxdata  = 8'h00;
  endtask

  // Collects up to n completed TX bytes within a cycle budget, tracking data stability under stall.
  task automatic capture(input int n, input bit toggle);
    logic [7:0] held;
    bit         holding;
    held = 8'h00;
    holding = 1'b0;
    rx_q.delete();
    stable_ok = 1'b1;
    for (int cyc = 0; cyc < 300 && rx_q.size() < n; cyc++) begin
      com_txready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (com_txvalid) begin
        if (holding && com_txdata !== held) stable_ok = 1'b0;
        if (com_txready) begin
          rx_q.push_back(com_txdata);
          holding = 1'b0;
        end else begin
          held = com_txdata;
          holding = 1'b1;
        end
      end
      tick();
    end
    com_txready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({com_txvalid, com_txdata, start, soft_rstn, busy} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got txv=%b txd=%h start=%b srst=%b busy=%b", com_txvalid, com_txdata, start, soft_rstn, busy);
    end
    tests_run++;
    if (sw_int !== rst_bank) begin
      tests_failed++;
      $display("FAIL reset_sw_int: got %h expected %h", sw_int, rst_bank);
    end
    tests_run++;
    if (sw_frac !== rst_bank) begin
      tests_failed++;
      $display("FAIL reset_sw_frac: got %h expected %h", sw_frac, rst_bank);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_frac_write();
    bit early_tx;
    early_tx = 1'b0;
    com_txready = 1'b1;
    send_byte(8'h02);
    for (int i = 0; i < NUM_CHAN; i++) begin
      tick();
      tick();
      if (com_txvalid) early_tx = 1'b1;
      send_byte(8'(i + 1));
      if (i < NUM_CHAN - 1 && com_txvalid) early_tx = 1'b1;
    end
    tests_run++;
    if (sw_frac !== exp_frac) begin
      tests_failed++;
      $display("FAIL frac_before_commit: got %h expected %h", sw_frac, exp_frac);
    end
    tick();
    for (int i = 0; i < NUM_CHAN; i++) exp_frac[i] = 8'(i + 1);
    tests_run++;
    if (sw_frac !== exp_frac) begin
      tests_failed++;
      $display("FAIL frac_commit: got %h expected %h", sw_frac, exp_frac);
    end
    tests_run++;
    if (early_tx !== 1'b0) begin
      tests_failed++;
      $display("FAIL frac_no_early_tx: saw txvalid during payload");
    end
    capture(1, 1'b0);
    tests_run++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL frac_ack: got %0d bytes first=%h expected 1 byte a5", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'h00);
    end
    tests_run++;
    if (com_txvalid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL frac_idle_after: txvalid=%b busy=%b expected 0 0", com_txvalid, busy);
    end
    tests_run++;
    if (sw_int !== exp_int) begin
      tests_failed++;
      $display("FAIL frac_int_untouched: got %h expected %h", sw_int, exp_int);
    end
  endtask

  task automatic test_readback();
    logic [7:0] want;
    send_byte(8'h05);
    capture(2 * NUM_CHAN, 1'b0);
    tests_run++;
    if (rx_q.size() != 2 * NUM_CHAN) begin
      tests_failed++;
      $display("FAIL rb_count: got %0d bytes expected %0d", rx_q.size(), 2 * NUM_CHAN);
    end
    for (int i = 0; i < rx_q.size() && i < 2 * NUM_CHAN; i++) begin
      want = (i < NUM_CHAN) ? 8'(exp_frac[i]) : 8'(exp_int[i - NUM_CHAN]);
      tests_run++;
      if (rx_q[i] !== want) begin
        tests_failed++;
        $display("FAIL rb_byte[%0d]: got %h expected %h", i, rx_q[i], want);
      end
    end
    tests_run++;
    if (com_txvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rb_end: txvalid=%b expected 0", com_txvalid);
    end
  endtask

  task automatic test_int_timeout();
    int w;
    send_byte(8'h03);
    for (int i = 0; i < 7; i++) send_byte(8'h40 + 8'(i));
    w = 0;
    while (w < RX_TIMEOUT + 10 && !com_txvalid) begin
      tick();
      w++;
    end
    tests_run++;
    if (w < RX_TIMEOUT - 1 || w > RX_TIMEOUT + 1) begin
      tests_failed++;
      $display("FAIL timeout_delay: got %0d cycles expected about %0d", w, RX_TIMEOUT);
    end
    capture(1, 1'b0);
    tests_run++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hEE) begin
      tests_failed++;
      $display("FAIL timeout_nak: got %0d bytes first=%h expected 1 byte ee", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'h00);
    end
    tests_run++;
    if (sw_int !== exp_int || sw_frac !== exp_frac) begin
      tests_failed++;
      $display("FAIL timeout_no_commit: int=%h frac=%h expected int=%h frac=%h", sw_int, sw_frac, exp_int, exp_frac);
    end
    send_byte(8'h03);
    for (int i = 0; i < NUM_CHAN; i++) send_byte(8'h10 + 8'(i));
    tick();
    for (int i = 0; i < NUM_CHAN; i++) exp_int[i] = 8'h10 + 8'(i);
    tests_run++;
    if (sw_int !== exp_int) begin
      tests_failed++;
      $display("FAIL int_commit: got %h expected %h", sw_int, exp_int);
    end
    capture(1, 1'b0);
    tests_run++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL int_ack: got %0d bytes first=%h expected 1 byte a5", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'h00);
    end
  endtask

  task automatic test_mse_stream();
    mse_data  = 64'h0807060504030201;
    mse_valid = 1'b1;
    tick();
    mse_valid = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) send_byte(8'h06);
      capture(MSE_BYTES, 1'b1);
      tests_run++;
      if (rx_q.size() != MSE_BYTES) begin
        tests_failed++;
        $display("FAIL mse_count[%0d]: got %0d bytes expected %0d", pass, rx_q.size(), MSE_BYTES);
      end
      for (int i = 0; i < rx_q.size() && i < MSE_BYTES; i++) begin
        tests_run++;
        if (rx_q[i] !== 8'(i + 1)) begin
          tests_failed++;
          $display("FAIL mse_byte[%0d][%0d]: got %h expected %h", pass, i, rx_q[i], 8'(i + 1));
        end
      end
      tests_run++;
      if (stable_ok !== 1'b1) begin
        tests_failed++;
        $display("FAIL mse_stable[%0d]: txdata changed while stalled", pass);
      end
    end
    tick();
    tick();
    tick();
    tests_run++;
    if (com_txvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mse_no_repeat: txvalid=%b expected 0", com_txvalid);
    end
  endtask

  task automatic test_start_mse();
    mse_data  = 64'hA1A2A3A4A5A6A7A8;
    mse_valid = 1'b1;
    send_byte(8'h01);
    mse_valid = 1'b0;
    tests_run++;
    if (start !== 1'b1 || com_txvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_pulse: start=%b txvalid=%b expected 1 0", start, com_txvalid);
    end
    tick();
    tests_run++;
    if (start !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_once: start=%b expected 0", start);
    end
    tick();
    mse_data  = 64'hB1B2B3B4B5B6B7B8;
    mse_valid = 1'b1;
    tick();
    mse_valid = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      capture(MSE_BYTES, 1'b0);
      tests_run++;
      if (rx_q.size() != MSE_BYTES) begin
        tests_failed++;
        $display("FAIL smse_count[%0d]: got %0d bytes expected %0d", pass, rx_q.size(), MSE_BYTES);
      end
      for (int i = 0; i < rx_q.size() && i < MSE_BYTES; i++) begin
        tests_run++;
        if (rx_q[i] !== ((pass == 0 ? 8'hA8 : 8'hB8) - 8'(i))) begin
          tests_failed++;
          $display("FAIL smse_byte[%0d][%0d]: got %h expected %h", pass, i, rx_q[i], (pass == 0 ? 8'hA8 : 8'hB8) - 8'(i));
        end
      end
    end
    tick();
    tests_run++;
    if (com_txvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL smse_end: txvalid=%b expected 0", com_txvalid);
    end
  endtask

  task automatic test_soft_reset();
    int  low;
    bit  seen_tx;
    mse_data  = 64'hC1C2C3C4C5C6C7C8;
    mse_valid = 1'b1;
    send_byte(8'h04);
    mse_valid = 1'b0;
    tests_run++;
    if (soft_rstn !== 1'b0) begin
      tests_failed++;
      $display("FAIL srst_first_cycle: soft_rstn=%b expected 0", soft_rstn);
    end
    low = (soft_rstn === 1'b0) ? 1 : 0;
    seen_tx = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (soft_rstn === 1'b0) low++;
      if (com_txvalid) seen_tx = 1'b1;
    end
    tests_run++;
    if (low != RST_CYCLES) begin
      tests_failed++;
      $display("FAIL srst_width: got %0d low cycles expected %0d", low, RST_CYCLES);
    end
    tests_run++;
    if (seen_tx !== 1'b0) begin
      tests_failed++;
      $display("FAIL srst_mse_discard: pending MSE was transmitted");
    end
    tests_run++;
    if (sw_int !== exp_int || sw_frac !== exp_frac) begin
      tests_failed++;
      $display("FAIL srst_switches: int=%h frac=%h expected int=%h frac=%h", sw_int, sw_frac, exp_int, exp_frac);
    end
  endtask

  task automatic test_nak();
    logic [7:0] cmds [2];
    cmds[0] = 8'h7F;
    cmds[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      send_byte(cmds[k]);
      tests_run++;
      if (busy !== 1'b1 || com_txvalid !== 1'b1) begin
        tests_failed++;
        $display("FAIL nak_busy[%0d]: busy=%b txvalid=%b expected 1 1", k, busy, com_txvalid);
      end
      capture(1, 1'b0);
      tests_run++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'hEE) begin
        tests_failed++;
        $display("FAIL nak_byte[%0d]: got %0d bytes first=%h expected 1 byte ee", k, rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'h00);
      end
    end
  endtask

  task automatic test_reset_mid_readback();
    send_byte(8'h05);
    capture(5, 1'b0);
    tests_run++;
    if (rx_q.size() != 5) begin
      tests_failed++;
      $display("FAIL rbrst_count: got %0d bytes expected 5", rx_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < 5; i++) begin
      tests_run++;
      if (rx_q[i] !== 8'(exp_frac[i])) begin
        tests_failed++;
        $display("FAIL rbrst_byte[%0d]: got %h expected %h", i, rx_q[i], 8'(exp_frac[i]));
      end
    end
    com_txready = 1'b1;
    rstn = 1'b0;
    tick();
    tests_run++;
    if (com_txvalid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rbrst_abort: txvalid=%b busy=%b expected 0 0", com_txvalid, busy);
    end
    tests_run++;
    if (sw_int !== rst_bank || sw_frac !== rst_bank) begin
      tests_failed++;
      $display("FAIL rbrst_switches: int=%h frac=%h expected %h", sw_int, sw_frac, rst_bank);
    end
    rstn = 1'b1;
    com_txready = 1'b0;
    tick();
    tick();
    tests_run++;
    if (com_txvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rbrst_quiet: txvalid=%b expected 0", com_txvalid);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_CHAN; i++) rst_bank[i] = 8'h1E;
    exp_int  = rst_bank;
    exp_frac = rst_bank;
    test_reset();
    test_frac_write();
    test_readback();
    test_int_timeout();
    test_mse_stream();
    test_start_mse();
    test_soft_reset();
    test_nak();
    test_reset_mid_readback();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
